pll_phase_ctrl: RTL

- Runtime dynamic phase-shift controller for the board PLL; successor to the fixed-phase PLL wrapper, generalised to N output counters with signed multi-step moves.
- Sits between core logic (e.g. SDRAM clock alignment, video phase trim) and the PLL dynamic-phase port: phase_en/updn/cntsel/phase_done.
- Tracks the accumulated step offset per counter and reports completion, busy and error status.

---
 rtl/pll_phase_ctrl_if.sv | 32 +++
 rtl/pll_phase_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl_if.sv
// Command, status and PLL dynamic-phase signals of the phase-shift controller.
// master: core logic plus PLL side; slave: the controller itself.
interface pll_phase_ctrl_if #(
    parameter int unsigned CNTSEL_W = 5,
    parameter int unsigned STEP_W   = 12
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CNTSEL_W-1:0] cmd_cnt;
    logic [STEP_W-1:0]   cmd_steps;
    logic                cmd_clear;
    logic                done;
    logic                err;
    logic                busy;
    logic                pll_locked;
    logic                phase_done;
    logic                phase_en;
    logic                updn;
    logic [CNTSEL_W-1:0] cntsel;
    logic [CNTSEL_W-1:0] acc_sel;
    logic [STEP_W-1:0]   acc_out;

    modport master (
        output cmd_valid, cmd_cnt, cmd_steps, cmd_clear, acc_sel, pll_locked, phase_done,
        input  cmd_ready, done, err, busy, phase_en, updn, cntsel, acc_out
    );

    modport slave (
        input  cmd_valid, cmd_cnt, cmd_steps, cmd_clear, acc_sel, pll_locked, phase_done,
        output cmd_ready, done, err, busy, phase_en, updn, cntsel, acc_out
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift controller: turns signed multi-step requests into
// phase_en/updn/cntsel step sequences and tracks the net offset per counter.
module pll_phase_ctrl #(
    parameter int unsigned NUM_CNT   = 2,
    parameter int unsigned CNTSEL_W  = 5,
    parameter int unsigned STEP_W    = 12,
    parameter int unsigned EN_CYCLES = 2,
    parameter int unsigned TIMEOUT   = 1023
) (
    input logic             clk,
    input logic             rst_n,
    pll_phase_ctrl_if.slave bus
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitLock = 3'd1;
    localparam logic [2:0] StStepEn   = 3'd2;
    localparam logic [2:0] StWaitLo   = 3'd3;
    localparam logic [2:0] StWaitHi   = 3'd4;
    localparam logic [2:0] StFinish   = 3'd5;

    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned EnW  = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [EnW-1:0]  EnLast  = EnW'(EN_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [1:0]          lock_sync_q, pdone_sync_q;
    logic                locked_s, pdone_s;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [EnW-1:0]      en_cnt_q, en_cnt_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                err_q, err_d;
    logic                updn_q, updn_d;
    logic [CNTSEL_W-1:0] cntsel_q, cntsel_d;
    logic [STEP_W-1:0]   acc_q [NUM_CNT];
    logic [STEP_W-1:0]   acc_d [NUM_CNT];

    logic [STEP_W-1:0]   steps_abs;
    logic                cnt_ok;
    logic                tmo_hit;

    assign locked_s  = lock_sync_q[1];
    assign pdone_s   = pdone_sync_q[1];
    // Magnitude of the most negative request still fits as an unsigned count.
    assign steps_abs = bus.cmd_steps[STEP_W-1] ? (-bus.cmd_steps) : bus.cmd_steps;
    assign cnt_ok    = (32'(bus.cmd_cnt) < NUM_CNT);
    assign tmo_hit   = (tmo_q == TmoLast);

    // Two-flop synchronisers for the asynchronous PLL status inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q  <= 2'b00;
            pdone_sync_q <= 2'b11;
        end else begin
            lock_sync_q  <= {lock_sync_q[0], bus.pll_locked};
            pdone_sync_q <= {pdone_sync_q[0], bus.phase_done};
        end
    end

    // Next-state logic for the step sequencer, timeout and accumulators.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        en_cnt_d = en_cnt_q;
        rem_d    = rem_q;
        err_d    = err_q;
        updn_d   = updn_q;
        cntsel_d = cntsel_q;
        acc_d    = acc_q;

        case (state_q)
            StIdle: begin
                if (bus.cmd_clear) begin
                    for (int i = 0; i < int'(NUM_CNT); i++) begin
                        acc_d[i] = '0;
                    end
                end
                if (bus.cmd_valid) begin
                    err_d = 1'b0;
                    rem_d = steps_abs;
                    if (!cnt_ok) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else if (bus.cmd_steps == '0) begin
                        state_d = StFinish;
                    end else begin
                        cntsel_d = bus.cmd_cnt;
                        updn_d   = ~bus.cmd_steps[STEP_W-1];
                        tmo_d    = '0;
                        state_d  = StWaitLock;
                    end
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    en_cnt_d = '0;
                    state_d  = StStepEn;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StStepEn: begin
                if (!locked_s) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else if (en_cnt_q == EnLast) begin
                    tmo_d   = '0;
                    state_d = StWaitLo;
                end else begin
                    en_cnt_d = en_cnt_q + EnW'(1);
                end
            end
            StWaitLo: begin
                if (!locked_s) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else if (!pdone_s) begin
                    tmo_d   = '0;
                    state_d = StWaitHi;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitHi: begin
                if (!locked_s) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else if (pdone_s) begin
                    // Step acknowledged: commit it to the selected accumulator.
                    for (int i = 0; i < int'(NUM_CNT); i++) begin
                        if (cntsel_q == CNTSEL_W'(i)) begin
                            acc_d[i] = updn_q ? (acc_q[i] + STEP_W'(1))
                                              : (acc_q[i] - STEP_W'(1));
                        end
                    end
                    rem_d = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = StFinish;
                    end else begin
                        en_cnt_d = '0;
                        state_d  = StStepEn;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            en_cnt_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            updn_q   <= 1'b0;
            cntsel_q <= '0;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            en_cnt_q <= en_cnt_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            updn_q   <= updn_d;
            cntsel_q <= cntsel_d;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Accumulator read port; out-of-range indices read as zero.
    always_comb begin
        bus.acc_out = '0;
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (bus.acc_sel == CNTSEL_W'(i)) begin
                bus.acc_out = acc_q[i];
            end
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StFinish);
    assign bus.err       = err_q;
    assign bus.updn      = updn_q;
    assign bus.cntsel    = cntsel_q;
    // Gated by the live lock so a lock loss kills the strobe without waiting a cycle.
    assign bus.phase_en  = (state_q == StStepEn) && locked_s;

endmodule
